vq18_sort_ctrl: RTL

VQ18_SORT_CTRL -- requirements
Module: vq18_sort_ctrl

---
 rtl/vq18_sort_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vq18_sort_ctrl.sv
// ---------------------------------------------------------------------------
// vq18_sort_ctrl
//
// Purpose:
//   Sorts a vector of NEL signed W-bit VQ elements into ascending order with
//   an odd-even transposition network that runs one pass per clock. Each
//   element carries its original lane address through the sort, so the
//   caller gets both the ordered values and the lane each value came from.
//   Ties never swap, so equal values keep their original relative order.
//
// Ports:
//   clk    in   1       single clock; all state changes on the rising edge
//   rst_n  in   1       asynchronous active-low reset
//   Start  in   1       sort request; accepted only in IDLE (pulse or level)
//   Din    in   NEL*W   signed input elements, lane i at [i*W +: W]
//   Busy   out  1       high while a sort is in progress
//   Done   out  1       one-cycle pulse when Dout/Ado carry a new result
//   Dout   out  NEL*W   sorted values, ascending; lane NEL-1 holds the max
//   Ado    out  NEL*5   original lane address of each Dout lane
//
// Configuration:
//   VQ18_EARLY_EXIT_EN  when defined, the sort stops as soon as two
//                       consecutive passes make no swap (minimum 2 passes).
//                       When undefined, exactly NEL passes are always run
//                       and no swap tracking is built. Results are identical.
// ---------------------------------------------------------------------------
module vq18_sort_ctrl #(
    parameter int NEL = 18,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [NEL*W-1:0] Din,
    output logic             Busy,
    output logic             Done,
    output logic [NEL*W-1:0] Dout,
    output logic [NEL*5-1:0] Ado
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [W-1:0] val     [NEL];
    logic signed [W-1:0] val_nxt [NEL];
    logic        [4:0]   adr     [NEL];
    logic        [4:0]   adr_nxt [NEL];
    logic        [5:0]   pass_cnt;

`ifdef VQ18_EARLY_EXIT_EN
    logic swap_any;
    logic prev_clean;
`endif

    // One transposition pass over the working array. Even passes pair lanes
    // (0,1),(2,3)...; odd passes pair (1,2),(3,4)... so the end lanes rest on
    // odd passes. The pair start parity matches the pass parity, which is
    // just bit 0 of the pass counter. Pairs within a pass never overlap, so
    // every pair can be resolved in parallel from the current array.
    always_comb begin
        val_nxt = val;
        adr_nxt = adr;
`ifdef VQ18_EARLY_EXIT_EN
        swap_any = 1'b0;
`endif
        for (int k = 0; k < NEL - 1; k++) begin
            if (k[0] == pass_cnt[0]) begin
                if (val[k+1] < val[k]) begin
                    val_nxt[k]   = val[k+1];
                    val_nxt[k+1] = val[k];
                    adr_nxt[k]   = adr[k+1];
                    adr_nxt[k+1] = adr[k];
`ifdef VQ18_EARLY_EXIT_EN
                    swap_any     = 1'b1;
`endif
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A sort always ends after NEL passes; with early exit
    // it may also end once a clean pass follows another clean pass, since an
    // even and an odd pass with no swaps together prove the array is sorted.
    // DONE lasts one cycle and always returns to IDLE, so Start arriving in
    // SORT or DONE is simply never looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                if (pass_cnt == 6'(NEL - 1)) begin
                    state_nxt = DONE;
                end
`ifdef VQ18_EARLY_EXIT_EN
                else if (!swap_any && prev_clean) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. Busy follows the SORT state one cycle
    // late so it rises the cycle after Start is taken and drops in the same
    // cycle Done pulses; that leaves the Done cycle free to accept a held
    // Start. Dout/Ado are only written from DONE, so intermediate passes are
    // never visible and the previous result holds throughout a new sort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Dout     <= '0;
            Ado      <= '0;
            pass_cnt <= '0;
            for (int i = 0; i < NEL; i++) begin
                val[i] <= '0;
                adr[i] <= '0;
            end
`ifdef VQ18_EARLY_EXIT_EN
            prev_clean <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            Busy <= (state == SORT);
            case (state)
                IDLE: begin
                    if (Start) begin
                        pass_cnt <= '0;
                        for (int i = 0; i < NEL; i++) begin
                            val[i] <= Din[i*W +: W];
                            adr[i] <= 5'(i);
                        end
`ifdef VQ18_EARLY_EXIT_EN
                        prev_clean <= 1'b0;
`endif
                    end
                end
                SORT: begin
                    val      <= val_nxt;
                    adr      <= adr_nxt;
                    pass_cnt <= pass_cnt + 6'd1;
`ifdef VQ18_EARLY_EXIT_EN
                    prev_clean <= !swap_any;
`endif
                end
                DONE: begin
                    Done <= 1'b1;
                    for (int i = 0; i < NEL; i++) begin
                        Dout[i*W +: W] <= val[i];
                        Ado[i*5 +: 5]  <= adr[i];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
